// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared types, constants and helpers for the display scheduler.
//               - state_t    : scheduler FSM states (IDLE, HOLD)
//               - DW_DEFAULT : default display data width (signed 11-bit)
//               - clog2      : index width helper; never returns less than 1
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    localparam int DW_DEFAULT = 11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Ceiling log2 with a floor of 1, so that a single-value range still
    // yields a legal one-bit vector.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : disp_pkg
`default_nettype wire

// File: rtl/disp_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : disp_rr_pick
// Description : Combinational winner selection for the display scheduler.
//               Urgent requesters win by lowest index; otherwise the first
//               requester found scanning upward from rr (with wrap) wins.
// Ports       : req     - level request per source
//               urgent  - per-source priority qualifier (gated by req)
//               rr      - round-robin start index
//               winner  - selected source index
//               valid   - at least one request is present
// Revision    : 1.0 - initial release
// ============================================================================
module disp_rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] urgent,
    input  logic [IW-1:0]      rr,
    output logic [IW-1:0]      winner,
    output logic               valid
);

    logic [NUM_SRC-1:0] w_urg;

    assign w_urg = req & urgent;
    assign valid = |req;

    // Both scans run from the far end toward the preferred position so the
    // last hit (lowest index / smallest offset from rr) is the one kept.
    always_comb begin
        int idx;
        winner = '0;
        idx    = 0;
        if (|w_urg) begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (w_urg[i]) begin
                    winner = IW'(i);
                end
            end
        end else begin
            for (int k = NUM_SRC - 1; k >= 0; k--) begin
                idx = int'(rr) + k;
                if (idx >= NUM_SRC) begin
                    idx = idx - NUM_SRC;
                end
                if (req[idx]) begin
                    winner = IW'(idx);
                end
            end
        end
    end

endmodule : disp_rr_pick
`default_nettype wire

// File: rtl/disp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : disp_scheduler
// Description : Time-shares the signed seven-segment display path between
//               NUM_SRC requesters. Each grant latches the source value,
//               pulses ack/disp_sel for one cycle, then holds the display for
//               DWELL_CYC cycles. Urgent requests may preempt a dwell.
// Ports       : clk       - system clock (rising edge)
//               rst       - asynchronous active-low reset
//               req       - level request per source
//               urgent    - per-source priority qualifier (with req)
//               src_data  - packed source values, source i at [i*DW +: DW]
//               ack       - one-hot pulse when a source value is latched
//               disp_sel  - one-cycle load strobe to the display driver
//               disp_data - latched value for the display driver
//               cur_src   - index of the last granted source
//               busy      - high while a dwell is running
// Revision    : 1.0 - initial release
// ============================================================================
module disp_scheduler
    import disp_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int DW        = DW_DEFAULT,
    parameter int DWELL_CYC = 50000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC-1:0]          req,
    input  logic [NUM_SRC-1:0]          urgent,
    input  logic [NUM_SRC*DW-1:0]       src_data,
    output logic [NUM_SRC-1:0]          ack,
    output logic                        disp_sel,
    output logic [DW-1:0]               disp_data,
    output logic [clog2(NUM_SRC)-1:0]   cur_src,
    output logic                        busy
);

    localparam int IW = clog2(NUM_SRC);
    localparam int CW = clog2(DWELL_CYC);

    state_t             r_state;
    logic [IW-1:0]      r_rr;
    logic [CW-1:0]      r_cnt;

    logic [IW-1:0]      w_win;
    logic               w_valid;
    logic [NUM_SRC-1:0] w_cur_oh;
    logic               w_preempt;
    logic               w_expire;
    logic               w_grant;
    logic [DW-1:0]      w_win_data;
    logic [IW-1:0]      w_rr_next;

    disp_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IW      (IW)
    ) u_pick (
        .req    (req),
        .urgent (urgent),
        .rr     (r_rr),
        .winner (w_win),
        .valid  (w_valid)
    );

    assign w_cur_oh   = NUM_SRC'(1) << cur_src;
    // The source currently on display can never preempt itself.
    assign w_preempt  = |(req & urgent & ~w_cur_oh);
    assign w_expire   = (r_cnt == CW'(DWELL_CYC - 1));
    assign w_grant    = (r_state == IDLE) ? w_valid
                                          : (w_preempt || (w_expire && w_valid));
    assign w_win_data = src_data[int'(w_win)*DW +: DW];
    assign w_rr_next  = (w_win == IW'(NUM_SRC - 1)) ? '0 : (w_win + IW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_rr      <= '0;
            r_cnt     <= '0;
            ack       <= '0;
            disp_sel  <= 1'b0;
            disp_data <= '0;
            cur_src   <= '0;
            busy      <= 1'b0;
        end else begin
            ack      <= '0;
            disp_sel <= 1'b0;
            if (w_grant) begin
                disp_data <= w_win_data;
                ack       <= NUM_SRC'(1) << w_win;
                disp_sel  <= 1'b1;
                cur_src   <= w_win;
                r_rr      <= w_rr_next;
                r_cnt     <= '0;
                r_state   <= HOLD;
                busy      <= 1'b1;
            end else if (r_state == HOLD) begin
                if (w_expire) begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

endmodule : disp_scheduler
`default_nettype wire
